// File: rtl/life_ctrl_pkg.sv
// Shared constants for the life_array_8x8 sequencer: FSM encodings and the
// board-to-word geometry (64 cells moved as four 16-bit words).
package life_ctrl_pkg;

  localparam int LIFE_WORDS  = 4;
  localparam int LIFE_SEL_W  = 2;
  localparam int LIFE_WORD_W = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_RUN  = 2'd2;
  localparam state_t ST_DUMP = 2'd3;

endpackage

// File: rtl/life_step_timer.sv
// Period down-counter: load sets it to period-1, it counts down while enabled
// and raises tick while the count sits at zero.
module life_step_timer #(
  parameter int PER_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [PER_W-1:0] period,
  output logic             tick
);

  logic [PER_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= period - PER_W'(1);
    end else if (enable && (count != '0)) begin
      count <= count - PER_W'(1);
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/life_array_ctrl.sv
// Sequencer for life_array_8x8: loads a board from the host, runs a number of
// generations at a programmed step period, then streams the board back.
module life_array_ctrl
  import life_ctrl_pkg::*;
#(
  parameter int GEN_W  = 16,
  parameter int PER_W  = 16,
  parameter int WORD_W = LIFE_WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              load_en,
  input  logic              abort,
  input  logic [GEN_W-1:0]  gens,
  input  logic [PER_W-1:0]  period,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [GEN_W-1:0]  gen_count,
  output logic [WORD_W-1:0] arr_vali,
  output logic [1:0]        arr_vali_sel,
  output logic              arr_write_enb,
  output logic [1:0]        arr_valo_sel,
  input  logic [WORD_W-1:0] arr_valo,
  output logic              arr_step
);

  localparam logic [LIFE_SEL_W-1:0] LAST_WORD = LIFE_SEL_W'(LIFE_WORDS - 1);

  state_t                state;
  logic [LIFE_SEL_W-1:0] widx;
  logic [GEN_W-1:0]      gens_q;
  logic [PER_W-1:0]      period_q;
  logic [PER_W-1:0]      per_eff;
  logic [GEN_W:0]        issued;
  logic                  start_ok, load_hs, dump_hs;
  logic                  enter_run, pulse_due, run_done, tick, tmr_load;

  assign busy          = (state != ST_IDLE);
  assign in_ready      = (state == ST_LOAD);
  assign out_valid     = (state == ST_DUMP);
  assign arr_vali      = in_data;
  assign arr_vali_sel  = widx;
  assign arr_valo_sel  = widx;
  assign out_data      = arr_valo;
  assign arr_write_enb = in_ready && in_valid && !abort;
  assign load_hs       = arr_write_enb;
  assign dump_hs       = out_valid && out_ready && !abort;
  assign start_ok      = (state == ST_IDLE) && start && !abort;

  // In IDLE the period port is still the live value, afterwards the latched copy.
  assign per_eff = (state == ST_IDLE) ? ((period == '0) ? PER_W'(1) : period) : period_q;

  // Pulses already counted plus the one currently on arr_step.
  assign issued    = {1'b0, gen_count} + {{GEN_W{1'b0}}, arr_step};
  assign enter_run = (start_ok && !load_en && (gens != '0)) ||
                     (load_hs && (widx == LAST_WORD) && (gens_q != '0));
  assign pulse_due = (state == ST_RUN) && tick && (issued < {1'b0, gens_q}) && !abort;
  assign run_done  = (state == ST_RUN) && !arr_step && (gen_count == gens_q);
  assign tmr_load  = enter_run || pulse_due;

  life_step_timer #(.PER_W(PER_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (tmr_load),
    .enable (state == ST_RUN),
    .period (per_eff),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (start_ok) begin
      gens_q   <= gens;
      period_q <= (period == '0) ? PER_W'(1) : period;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      widx      <= '0;
      gen_count <= '0;
      arr_step  <= 1'b0;
      done      <= 1'b0;
    end else begin
      arr_step <= 1'b0;
      done     <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
        widx  <= '0;
      end else begin
        case (state)
          ST_IDLE: if (start) begin
            gen_count <= '0;
            widx      <= '0;
            arr_step  <= enter_run;
            state     <= load_en ? ST_LOAD : ((gens != '0) ? ST_RUN : ST_DUMP);
          end
          ST_LOAD: if (load_hs) begin
            widx <= widx + LIFE_SEL_W'(1);
            if (widx == LAST_WORD) begin
              arr_step <= enter_run;
              state    <= (gens_q != '0) ? ST_RUN : ST_DUMP;
            end
          end
          ST_RUN: begin
            if (arr_step && (gen_count < gens_q)) gen_count <= gen_count + GEN_W'(1);
            if (pulse_due) arr_step <= 1'b1;
            // One quiet cycle after the final pulse lets the array settle.
            if (run_done) state <= ST_DUMP;
          end
          ST_DUMP: if (dump_hs) begin
            widx <= widx + LIFE_SEL_W'(1);
            if (widx == LAST_WORD) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_life_array_ctrl.sv
// Scoreboard bench for life_array_ctrl paired with a behavioural 8x8 life board
// (row r, column c is board bit r*8+c; word w holds rows 2w and 2w+1).
module tb_life_array_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, load_en, abort, in_valid, out_ready;
  logic [15:0] gens, period, in_data;
  logic        in_ready, out_valid, busy, done, arr_write_enb, arr_step;
  logic [15:0] out_data, gen_count, arr_vali, arr_valo;
  logic [1:0]  arr_vali_sel, arr_valo_sel;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int t0 = 0;
  int done_cnt = 0;
  int wr_cnt = 0;
  int dump_cyc = -1;
  int done_cyc = -1;
  int d0, w0;
  logic [15:0] sb_q[$];
  int step_q[$];
  int gc_q[$];
  logic [63:0] board = 64'd0;
  logic ov_prev = 1'b0;
  logic st_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  life_array_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .load_en(load_en), .abort(abort),
    .gens(gens), .period(period), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .gen_count(gen_count),
    .arr_vali(arr_vali), .arr_vali_sel(arr_vali_sel), .arr_write_enb(arr_write_enb),
    .arr_valo_sel(arr_valo_sel), .arr_valo(arr_valo), .arr_step(arr_step)
  );

  function automatic logic [63:0] life_next(input logic [63:0] b);
    logic [63:0] nb;
    int n;
    nb = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if ((dr != 0 || dc != 0) && (r + dr) >= 0 && (r + dr) < 8 &&
                (c + dc) >= 0 && (c + dc) < 8 && b[(r + dr) * 8 + (c + dc)])
              n++;
          end
        end
        nb[r * 8 + c] = (n == 3) || (b[r * 8 + c] && n == 2);
      end
    end
    return nb;
  endfunction

  assign arr_valo = board[{arr_valo_sel, 4'b0000} +: 16];

  always @(posedge clk) begin
    if (arr_write_enb) board[{arr_vali_sel, 4'b0000} +: 16] <= arr_vali;
    else if (arr_step) board <= life_next(board);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: scoreboard for readback words plus event logging.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (out_valid) begin
        if (sb_q.size() == 0) check("dump_unexpected", {15'd0, out_valid}, 32'd0);
        else if (out_ready) check("dump_word", out_data, sb_q.pop_front());
        else check("dump_hold", out_data, sb_q[0]);
      end
      if (out_valid && !ov_prev) dump_cyc = cyc;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (arr_write_enb) wr_cnt++;
      if (arr_step) step_q.push_back(cyc);
      if (st_prev) gc_q.push_back(int'(gen_count));
      ov_prev = out_valid;
      st_prev = arr_step;
    end
  end

  task automatic push_exp(input logic [15:0] a, b, c, d);
    sb_q.push_back(a); sb_q.push_back(b); sb_q.push_back(c); sb_q.push_back(d);
  endtask

  task automatic snap();
    d0 = done_cnt; w0 = wr_cnt;
    step_q.delete(); gc_q.delete();
  endtask

  task automatic do_start(input logic le, input logic [15:0] g, input logic [15:0] p);
    @(posedge clk); #1;
    load_en = le; gens = g; period = p; start = 1'b1; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic load_words(input logic [15:0] a, b, c, d, input int n, input bit toggle);
    logic [15:0] w[4];
    int k;
    w[0] = a; w[1] = b; w[2] = c; w[3] = d;
    for (int i = 0; i < n; i++) begin
      if (toggle) begin
        in_valid = 1'b0; in_data = 16'hDEAD;
        @(posedge clk); #1;
      end
      in_data = w[i]; in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 50) begin @(posedge clk); #1; k++; end
      if (!in_ready) check("load_ready_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = 16'hDEAD;
    end
  endtask

  task automatic wait_done(input int bound);
    int k = 0;
    while (done_cnt == d0 && k < bound) begin @(negedge clk); k++; end
    if (done_cnt == d0) check("done_timeout", 32'd0, 32'd1);
    repeat (3) @(negedge clk);
    check("done_pulses", done_cnt - d0, 32'd1);
    check("sb_empty", sb_q.size(), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b0; start = 1'b1; load_en = 1'b0; abort = 1'b0; gens = 16'd1;
    period = 16'd1; in_data = 16'h0; in_valid = 1'b0; out_ready = 1'b1;

    // Reset held low for two edges with start asserted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_step", arr_step, 0);
    check("rst_wen", arr_write_enb, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_gen_count", gen_count, 0);
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0;
    @(negedge clk);
    check("post_rst_idle", busy, 0);

    // Load and dump with zero generations.
    snap();
    push_exp(16'h0000, 16'h0E00, 16'h0000, 16'h0000);
    do_start(1'b1, 16'd0, 16'd1);
    load_words(16'h0000, 16'h0E00, 16'h0000, 16'h0000, 4, 1'b0);
    wait_done(50);
    check("g0_gen_count", gen_count, 0);
    check("g0_steps", step_q.size(), 0);
    check("g0_writes", wr_cnt - w0, 4);

    // Blinker: one generation turns the horizontal bar vertical.
    snap();
    push_exp(16'h0000, 16'h0404, 16'h0004, 16'h0000);
    do_start(1'b1, 16'd1, 16'd1);
    load_words(16'h0000, 16'h0E00, 16'h0000, 16'h0000, 4, 1'b0);
    wait_done(50);
    check("b1_steps", step_q.size(), 1);
    check("b1_gen_count", gen_count, 1);

    // Two generations with period 0 (treated as 1) restore the input.
    snap();
    push_exp(16'h0000, 16'h0E00, 16'h0000, 16'h0000);
    do_start(1'b1, 16'd2, 16'd0);
    load_words(16'h0000, 16'h0E00, 16'h0000, 16'h0000, 4, 1'b0);
    wait_done(50);
    check("b2_steps", step_q.size(), 2);
    if (step_q.size() == 2) check("b2_back_to_back", step_q[1] - step_q[0], 1);
    check("b2_gen_count", gen_count, 2);

    // Step spacing on the current board, with an ignored start while busy.
    snap();
    push_exp(16'h0000, 16'h0404, 16'h0004, 16'h0000);
    do_start(1'b0, 16'd3, 16'd4);
    repeat (2) @(posedge clk); #1;
    gens = 16'd1; period = 16'd1; load_en = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(60);
    check("sp_steps", step_q.size(), 3);
    for (int i = 0; i < 3 && i < step_q.size(); i++) check("sp_step_cycle", step_q[i] - t0, 1 + 4 * i);
    for (int i = 0; i < 3 && i < gc_q.size(); i++) check("sp_gen_count", gc_q[i], i + 1);
    check("sp_dump_entry", dump_cyc - t0, 11);
    check("sp_done_latency", done_cyc - t0, 15);
    check("sp_writes", wr_cnt - w0, 0);

    // Backpressure on both streams.
    snap();
    out_ready = 1'b0;
    push_exp(16'hA5A5, 16'h1234, 16'hFFFF, 16'h8001);
    do_start(1'b1, 16'd0, 16'd1);
    load_words(16'hA5A5, 16'h1234, 16'hFFFF, 16'h8001, 4, 1'b1);
    k = 0;
    while (!out_valid && k < 20) begin @(posedge clk); #1; k++; end
    check("bp_dump_reached", out_valid, 1);
    for (int i = 0; i < 4; i++) begin
      repeat (5) begin @(posedge clk); #1; end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    wait_done(20);
    out_ready = 1'b1;
    check("bp_writes", wr_cnt - w0, 4);

    // Zero generations without load: straight to readback.
    snap();
    push_exp(16'hA5A5, 16'h1234, 16'hFFFF, 16'h8001);
    do_start(1'b0, 16'd0, 16'd7);
    wait_done(20);
    check("dz_steps", step_q.size(), 0);
    check("dz_writes", wr_cnt - w0, 0);

    // Abort mid-run at generation 10.
    snap();
    do_start(1'b0, 16'd100, 16'd3);
    k = 0;
    while (gen_count != 16'd10 && k < 200) begin @(negedge clk); k++; end
    check("ab_reached_10", gen_count, 10);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("ab_idle", busy, 0);
    check("ab_gen_count", gen_count, 10);
    check("ab_steps", step_q.size(), 10);
    repeat (5) @(negedge clk);
    check("ab_no_done", done_cnt - d0, 0);
    check("ab_gen_hold", gen_count, 10);

    // Reset in the middle of a load.
    do_start(1'b1, 16'd5, 16'd1);
    load_words(16'h1111, 16'h2222, 16'h0, 16'h0, 2, 1'b0);
    check("rl_in_load", in_ready, 1);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rl_busy", busy, 0);
    check("rl_in_ready", in_ready, 0);
    check("rl_vali_sel", arr_vali_sel, 0);
    check("rl_valo_sel", arr_valo_sel, 0);
    check("rl_gen_count", gen_count, 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
